// File: rtl/control_sequencer.sv
// Moore control sequencer for a multi-cycle RISC datapath.
// Fetches, decodes IR[31:27] in T3 and drives datapath strobes.
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        con_ff,
  output logic        PCout,
  output logic        IncPC,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        read,
  output logic        write,
  output logic        RAMenable,
  output logic        Yin,
  output logic        ZLOin,
  output logic        ZLOout,
  output logic        Cout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        R15in,
  output logic        conin,
  output logic [4:0]  aluControl,
  output logic        run
);

  typedef enum logic [3:0] {
    S_RESET,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_T7,
    S_HALT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [4:0] w_op;
  logic       w_ld;
  logic       w_ldi;
  logic       w_st;
  logic       w_alur;
  logic       w_alui;
  logic       w_br;
  logic       w_jr;
  logic       w_jal;
  logic       w_halt;
  logic       w_nop;
  logic       w_mem;

  assign w_op   = IR[31:27];
  assign w_ld   = (w_op == 5'b00000);
  assign w_ldi  = (w_op == 5'b00001);
  assign w_st   = (w_op == 5'b00010);
  assign w_alur = (w_op >= 5'b00011) && (w_op <= 5'b01011);
  assign w_alui = (w_op >= 5'b01100) && (w_op <= 5'b01110);
  assign w_br   = (w_op == 5'b10011);
  assign w_jr   = (w_op == 5'b10100);
  assign w_jal  = (w_op == 5'b10101);
  assign w_halt = (w_op == 5'b11011);
  // Unassigned opcodes fall into the nop class.
  assign w_nop  = !(w_ld | w_ldi | w_st | w_alur | w_alui |
                    w_br | w_jr | w_jal | w_halt);
  assign w_mem  = w_ld | w_ldi | w_st;

  always_ff @(posedge clock) begin
    if (!clear) r_state <= S_RESET;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = S_T0;
    case (r_state)
      S_RESET: w_next = S_T0;
      S_T0:    w_next = S_T1;
      S_T1:    w_next = S_T2;
      S_T2:    w_next = S_T3;
      S_T3: begin
        unique case (1'b1)
          w_halt:      w_next = S_HALT;
          w_jr, w_nop: w_next = S_T0;
          default:     w_next = S_T4;
        endcase
      end
      S_T4: begin
        unique case (1'b1)
          w_jal, w_jr, w_nop, w_halt: w_next = S_T0;
          default:                    w_next = S_T5;
        endcase
      end
      S_T5: begin
        unique case (1'b1)
          w_ld, w_st, w_br: w_next = S_T6;
          default:          w_next = S_T0;
        endcase
      end
      S_T6: begin
        unique case (1'b1)
          w_ld, w_st: w_next = S_T7;
          default:    w_next = S_T0;
        endcase
      end
      S_T7:    w_next = S_T0;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_RESET;
    endcase
  end

  always_comb begin
    PCout      = 1'b0;
    IncPC      = 1'b0;
    PCin       = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    RAMenable  = 1'b0;
    Yin        = 1'b0;
    ZLOin      = 1'b0;
    ZLOout     = 1'b0;
    Cout       = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    BAout      = 1'b0;
    R15in      = 1'b0;
    conin      = 1'b0;
    aluControl = 5'b00000;
    run        = 1'b1;
    case (r_state)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
      end
      S_T1: begin
        read      = 1'b1;
        RAMenable = 1'b1;
        MDRin     = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        unique case (1'b1)
          w_alur, w_alui: begin
            Grb  = 1'b1;
            Rout = 1'b1;
            Yin  = 1'b1;
          end
          w_mem: begin
            Grb   = 1'b1;
            Rout  = 1'b1;
            BAout = 1'b1;
            Yin   = 1'b1;
          end
          w_br: begin
            Gra   = 1'b1;
            Rout  = 1'b1;
            conin = 1'b1;
          end
          w_jr: begin
            Gra  = 1'b1;
            Rout = 1'b1;
            PCin = 1'b1;
          end
          w_jal: begin
            R15in = 1'b1;
            PCout = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        unique case (1'b1)
          w_alur: begin
            Grc        = 1'b1;
            Rout       = 1'b1;
            ZLOin      = 1'b1;
            aluControl = w_op;
          end
          w_alui: begin
            Cout       = 1'b1;
            ZLOin      = 1'b1;
            aluControl = w_op;
          end
          w_mem: begin
            Cout       = 1'b1;
            ZLOin      = 1'b1;
            aluControl = 5'b00011;
          end
          w_br: begin
            PCout = 1'b1;
            Yin   = 1'b1;
          end
          w_jal: begin
            Gra  = 1'b1;
            Rout = 1'b1;
            PCin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        unique case (1'b1)
          w_alur, w_alui, w_ldi: begin
            ZLOout = 1'b1;
            Gra    = 1'b1;
            Rin    = 1'b1;
          end
          w_ld, w_st: begin
            ZLOout = 1'b1;
            MARin  = 1'b1;
          end
          w_br: begin
            Cout       = 1'b1;
            ZLOin      = 1'b1;
            aluControl = 5'b00011;
          end
          default: ;
        endcase
      end
      S_T6: begin
        unique case (1'b1)
          w_ld: begin
            read      = 1'b1;
            RAMenable = 1'b1;
            MDRin     = 1'b1;
          end
          w_st: begin
            Gra   = 1'b1;
            Rout  = 1'b1;
            MDRin = 1'b1;
          end
          w_br: begin
            // Taken branch only; con_ff is sampled nowhere else.
            ZLOout = con_ff;
            PCin   = con_ff;
          end
          default: ;
        endcase
      end
      S_T7: begin
        unique case (1'b1)
          w_ld: begin
            MDRout = 1'b1;
            Gra    = 1'b1;
            Rin    = 1'b1;
          end
          w_st: begin
            write     = 1'b1;
            RAMenable = 1'b1;
          end
          default: ;
        endcase
      end
      S_HALT: run = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer.
// Compares every output of each state against hand-derived words.
module tb_control_sequencer;

  logic        clock;
  logic        clear;
  logic [31:0] IR;
  logic        con_ff;
  logic        PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin;
  logic        read, write, RAMenable, Yin, ZLOin, ZLOout, Cout;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, R15in, conin, run;
  logic [4:0]  aluControl;

  int total = 0;
  int bad   = 0;

  localparam logic [22:0] B_PCO = 23'd1 << 22;
  localparam logic [22:0] B_INC = 23'd1 << 21;
  localparam logic [22:0] B_PCI = 23'd1 << 20;
  localparam logic [22:0] B_MAR = 23'd1 << 19;
  localparam logic [22:0] B_MDI = 23'd1 << 18;
  localparam logic [22:0] B_MDO = 23'd1 << 17;
  localparam logic [22:0] B_IRI = 23'd1 << 16;
  localparam logic [22:0] B_RD  = 23'd1 << 15;
  localparam logic [22:0] B_WR  = 23'd1 << 14;
  localparam logic [22:0] B_RAM = 23'd1 << 13;
  localparam logic [22:0] B_YIN = 23'd1 << 12;
  localparam logic [22:0] B_ZI  = 23'd1 << 11;
  localparam logic [22:0] B_ZO  = 23'd1 << 10;
  localparam logic [22:0] B_CO  = 23'd1 << 9;
  localparam logic [22:0] B_GA  = 23'd1 << 8;
  localparam logic [22:0] B_GB  = 23'd1 << 7;
  localparam logic [22:0] B_GC  = 23'd1 << 6;
  localparam logic [22:0] B_RI  = 23'd1 << 5;
  localparam logic [22:0] B_RO  = 23'd1 << 4;
  localparam logic [22:0] B_BA  = 23'd1 << 3;
  localparam logic [22:0] B_R15 = 23'd1 << 2;
  localparam logic [22:0] B_CON = 23'd1 << 1;
  localparam logic [22:0] B_RUN = 23'd1;

  control_sequencer dut (
    .clock(clock), .clear(clear), .IR(IR), .con_ff(con_ff),
    .PCout(PCout), .IncPC(IncPC), .PCin(PCin),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .read(read), .write(write), .RAMenable(RAMenable),
    .Yin(Yin), .ZLOin(ZLOin), .ZLOout(ZLOout), .Cout(Cout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .R15in(R15in), .conin(conin),
    .aluControl(aluControl), .run(run)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [27:0] w_obs;
  assign w_obs = {PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin,
                  read, write, RAMenable, Yin, ZLOin, ZLOout, Cout,
                  Gra, Grb, Grc, Rin, Rout, BAout, R15in, conin,
                  run, aluControl};

  task automatic chk(input string tag,
                     input logic [27:0] got,
                     input logic [27:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // Wait to the next falling edge, then compare all outputs.
  task automatic cyc(input string tag,
                     input logic [22:0] bits,
                     input logic [4:0] alu);
    @(negedge clock);
    chk(tag, w_obs, {bits, alu});
  endtask

  // T0 check confirms the previous instruction returned to fetch.
  task automatic fetch(input string tag, input logic [4:0] op);
    cyc({tag, "_t0"}, B_PCO | B_MAR | B_INC | B_RUN, 5'd0);
    IR = {op, 27'h0123456};
    cyc({tag, "_t1"}, B_RD | B_RAM | B_MDI | B_RUN, 5'd0);
    cyc({tag, "_t2"}, B_MDO | B_IRI | B_RUN, 5'd0);
  endtask

  initial begin
    clear  = 1'b0;
    IR     = 32'h0;
    con_ff = 1'b0;
    cyc("reset", B_RUN, 5'd0);
    clear = 1'b1;

    fetch("jal", 5'b10101);
    cyc("jal_t3", B_R15 | B_PCO | B_RUN, 5'd0);
    cyc("jal_t4", B_GA | B_RO | B_PCI | B_RUN, 5'd0);

    fetch("add", 5'b00011);
    cyc("add_t3", B_GB | B_RO | B_YIN | B_RUN, 5'd0);
    cyc("add_t4", B_GC | B_RO | B_ZI | B_RUN, 5'b00011);
    cyc("add_t5", B_ZO | B_GA | B_RI | B_RUN, 5'd0);

    fetch("alur_hi", 5'b01011);
    cyc("alur_hi_t3", B_GB | B_RO | B_YIN | B_RUN, 5'd0);
    cyc("alur_hi_t4", B_GC | B_RO | B_ZI | B_RUN, 5'b01011);
    cyc("alur_hi_t5", B_ZO | B_GA | B_RI | B_RUN, 5'd0);

    fetch("addi", 5'b01100);
    cyc("addi_t3", B_GB | B_RO | B_YIN | B_RUN, 5'd0);
    cyc("addi_t4", B_CO | B_ZI | B_RUN, 5'b01100);
    cyc("addi_t5", B_ZO | B_GA | B_RI | B_RUN, 5'd0);

    con_ff = 1'b1;
    fetch("brt", 5'b10011);
    cyc("brt_t3", B_GA | B_RO | B_CON | B_RUN, 5'd0);
    cyc("brt_t4", B_PCO | B_YIN | B_RUN, 5'd0);
    cyc("brt_t5", B_CO | B_ZI | B_RUN, 5'b00011);
    cyc("brt_t6", B_ZO | B_PCI | B_RUN, 5'd0);

    con_ff = 1'b0;
    fetch("brn", 5'b10011);
    cyc("brn_t3", B_GA | B_RO | B_CON | B_RUN, 5'd0);
    cyc("brn_t4", B_PCO | B_YIN | B_RUN, 5'd0);
    cyc("brn_t5", B_CO | B_ZI | B_RUN, 5'b00011);
    cyc("brn_t6", B_RUN, 5'd0);

    fetch("ld", 5'b00000);
    cyc("ld_t3", B_GB | B_RO | B_BA | B_YIN | B_RUN, 5'd0);
    cyc("ld_t4", B_CO | B_ZI | B_RUN, 5'b00011);
    cyc("ld_t5", B_ZO | B_MAR | B_RUN, 5'd0);
    cyc("ld_t6", B_RD | B_RAM | B_MDI | B_RUN, 5'd0);
    cyc("ld_t7", B_MDO | B_GA | B_RI | B_RUN, 5'd0);

    fetch("ldi", 5'b00001);
    cyc("ldi_t3", B_GB | B_RO | B_BA | B_YIN | B_RUN, 5'd0);
    cyc("ldi_t4", B_CO | B_ZI | B_RUN, 5'b00011);
    cyc("ldi_t5", B_ZO | B_GA | B_RI | B_RUN, 5'd0);

    con_ff = 1'b1;
    fetch("jr", 5'b10100);
    cyc("jr_t3", B_GA | B_RO | B_PCI | B_RUN, 5'd0);

    fetch("nop", 5'b11010);
    cyc("nop_t3", B_RUN, 5'd0);

    fetch("undef", 5'b11111);
    cyc("undef_t3", B_RUN, 5'd0);

    fetch("gap", 5'b01111);
    cyc("gap_t3", B_RUN, 5'd0);
    con_ff = 1'b0;

    fetch("st", 5'b00010);
    cyc("st_t3", B_GB | B_RO | B_BA | B_YIN | B_RUN, 5'd0);
    cyc("st_t4", B_CO | B_ZI | B_RUN, 5'b00011);
    cyc("st_t5", B_ZO | B_MAR | B_RUN, 5'd0);
    cyc("st_t6", B_GA | B_RO | B_MDI | B_RUN, 5'd0);
    clear = 1'b0;
    cyc("st_rst", B_RUN, 5'd0);
    clear = 1'b1;

    fetch("st2", 5'b00010);
    cyc("st2_t3", B_GB | B_RO | B_BA | B_YIN | B_RUN, 5'd0);
    cyc("st2_t4", B_CO | B_ZI | B_RUN, 5'b00011);
    cyc("st2_t5", B_ZO | B_MAR | B_RUN, 5'd0);
    cyc("st2_t6", B_GA | B_RO | B_MDI | B_RUN, 5'd0);
    cyc("st2_t7", B_WR | B_RAM | B_RUN, 5'd0);

    fetch("halt", 5'b11011);
    cyc("halt_t3", B_RUN, 5'd0);
    for (int i = 0; i < 12; i++)
      cyc("halt_hold", 23'd0, 5'd0);
    clear = 1'b0;
    cyc("halt_rst", B_RUN, 5'd0);
    clear = 1'b1;
    cyc("halt_t0", B_PCO | B_MAR | B_INC | B_RUN, 5'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port clear, input, 1, reset, synchronous, active-low.
REQ-003 SHALL have port IR, input, 32, current instruction from the datapath IR; opcode = IR[31:27].
REQ-004 SHALL have port con_ff, input, 1, branch-condition flag from the datapath CON FF.
REQ-005 SHALL have ports PCout, IncPC, PCin, output, 1 each, PC bus drive, increment, load.
REQ-006 SHALL have ports MARin, MDRin, MDRout, IRin, output, 1 each, memory-interface register strobes.
REQ-007 SHALL have ports read, write, RAMenable, output, 1 each, RAM access controls.
REQ-008 SHALL have ports Yin, ZLOin, ZLOout, Cout, output, 1 each, ALU operand, result and constant strobes.
REQ-009 SHALL have ports Gra, Grb, Grc, Rin, Rout, BAout, R15in, output, 1 each, register-file select and strobes.
REQ-010 SHALL have port conin, output, 1, CON FF load strobe.
REQ-011 SHALL have port aluControl, output, 5, ALU operation code.
REQ-012 SHALL have port run, output, 1, high unless in HALT.

Function
REQ-013 SHALL be a Moore FSM; outputs decode from current state and IR only and are held for the whole state cycle; unlisted outputs are 0; aluControl is 5'b00000 unless stated.
REQ-014 SHALL have states RESET, T0..T7, HALT; every non-HALT state advances exactly one step per clock.
REQ-015 SHALL fetch: T0 PCout,MARin,IncPC; T1 read,RAMenable,MDRin; T2 MDRout,IRin; T2->T3 always.
REQ-016 SHALL decode opcode in T3 from IR. Classes: ld 00000, ldi 00001, st 00010, ALU-reg 00011-01011, ALU-imm 01100-01110, br 10011, jr 10100, jal 10101, nop 11010, halt 11011; every other opcode SHALL be treated as nop.
REQ-017 ALU-reg SHALL be: T3 Grb,Rout,Yin; T4 Grc,Rout,ZLOin, aluControl=opcode; T5 ZLOout,Gra,Rin; then T0.
REQ-018 ALU-imm SHALL be: T3 Grb,Rout,Yin; T4 Cout,ZLOin, aluControl=opcode; T5 ZLOout,Gra,Rin; then T0.
REQ-019 ldi SHALL be: T3 Grb,Rout,BAout,Yin; T4 Cout,ZLOin, aluControl=00011; T5 ZLOout,Gra,Rin; then T0.
REQ-020 ld SHALL be: T3,T4 as ldi; T5 ZLOout,MARin; T6 read,RAMenable,MDRin; T7 MDRout,Gra,Rin; then T0.
REQ-021 st SHALL be: T3,T4 as ldi; T5 ZLOout,MARin; T6 Gra,Rout,MDRin; T7 write,RAMenable; then T0.
REQ-022 br SHALL be: T3 Gra,Rout,conin; T4 PCout,Yin; T5 Cout,ZLOin, aluControl=00011; T6 ZLOout,PCin only if con_ff=1 during T6, else no strobes; then T0.
REQ-023 jr SHALL be: T3 Gra,Rout,PCin; then T0.
REQ-024 jal SHALL be: T3 R15in,PCout; T4 Gra,Rout,PCin; then T0.
REQ-025 nop SHALL be: T3 no strobes; then T0.
REQ-026 halt SHALL go T3->HALT; HALT asserts no strobes, run=0, and holds until clear=0.
REQ-027 read and write SHALL never be high in the same cycle; PCin and PCout SHALL never be high in the same cycle.
REQ-028 con_ff SHALL be ignored outside br T6.

Reset
REQ-029 When clear=0 at a rising edge, the next state SHALL be RESET regardless of current state, including mid-instruction and HALT.
REQ-030 In RESET all strobe outputs and aluControl SHALL be 0 and run=1; RESET->T0 on the first rising edge with clear=1.
REQ-031 An instruction interrupted by reset SHALL NOT be resumed; the sequence restarts at T0 fetch.

Verification
REQ-032 Release clear, IR=opcode 10101 (jal): T0..T2 fetch strobes, T3 R15in+PCout, T4 Gra+Rout+PCin, then T0.
REQ-033 IR=00011 (add): T4 aluControl=00011 with Grc,Rout,ZLOin; T5 ZLOout,Gra,Rin; 6 cycles total T0..T5.
REQ-034 IR=10011 (br), con_ff=1 in T6: PCin+ZLOout in T6; repeat with con_ff=0: no PCin in T6.
REQ-035 IR=00000 (ld): read+RAMenable in both T1 and T6; MDRout+Gra+Rin in T7; 8 cycles total.
REQ-036 IR=11011 (halt): HALT after T3, run=0 for 10+ cycles; clear=0 for one edge gives RESET, then T0, run=1.
REQ-037 clear=0 during st T6: next cycle RESET with write=0, then fetch restarts at T0.
